level_meter_mc: RTL and testbench

LEVEL_METER_MC -- requirements
Module: level_meter_mc

---
 rtl/level_meter_pkg.sv | 30 +++
 rtl/level_bcd_seq.sv | 69 ++++++
 rtl/level_meter_mc.sv | 253 +++++++++++++++++++++++++
 tb/tb_level_meter_mc.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/level_meter_pkg.sv
// Shared types and constants for the multi-channel dBFS level meter.
// Optional peak hold is enabled with the LEVEL_METER_PEAK_HOLD_EN macro.
package level_meter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOG,
    ST_SCALE,
    ST_BCD,
    ST_NEXT,
    ST_DONE
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int LOG_FRAC_BITS = 3;
  localparam int DB_SCALE_Q    = 771;
  localparam int DB_ROUND      = 1024;
  localparam int DB_SHIFT      = 11;

  localparam int BIN_W = 10;
  localparam int BCD_W = 12;
  localparam int D_W   = 11;

  // Elaboration-time conversion used for the floor reset value.
  function automatic logic [BCD_W-1:0] to_bcd3(input int unsigned v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/level_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per cycle.
// A start pulse loads the value; done pulses once when bcd is final.
module level_bcd_seq
  import level_meter_pkg::*;
(
  input  logic             clk_48,
  input  logic             reset_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [BCD_W-1:0] sr_q, sr_d, adj;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             done_q, done_d;
  bcd_digit_t       dig;

  always_comb begin
    sr_d   = sr_q;
    bin_d  = bin_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    dig    = '0;
    adj    = sr_q;
    // Correct each digit before the shift so it carries properly into the next.
    for (int i = 0; i < 3; i++) begin
      dig = adj[4*i +: 4];
      if (dig >= 4'd5) adj[4*i +: 4] = dig + 4'd3;
    end
    if (start) begin
      sr_d  = '0;
      bin_d = bin;
      cnt_d = 4'(BIN_W);
      run_d = 1'b1;
    end else if (run_q) begin
      sr_d  = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
      bin_d = {bin_q[BIN_W-2:0], 1'b0};
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == 4'd1) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      sr_q   <= '0;
      bin_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      bin_q  <= bin_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign bcd  = sr_q;

endmodule

// File: rtl/level_meter_mc.sv
// Multi-channel windowed RMS level meter reporting dBFS as sign + 3 BCD digits.
// Define LEVEL_METER_PEAK_HOLD_EN for held-peak outputs; otherwise they mirror the level.
module level_meter_mc
  import level_meter_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int WIDTH        = 16,
  parameter int WINDOW_LOG2  = 13,
  parameter int DB_FLOOR     = 99,
  parameter int HOLD_WINDOWS = 8
) (
  input  logic                      clk_48,
  input  logic                      reset_n,
  input  logic                      sample_valid,
  input  logic [CHANNELS*WIDTH-1:0] samples,
  output logic [CHANNELS*12-1:0]    db_bcd,
  output logic [CHANNELS-1:0]       db_neg,
  output logic [CHANNELS*12-1:0]    peak_bcd,
  output logic [CHANNELS-1:0]       peak_neg,
  output logic                      level_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int AW      = 2*WIDTH + WINDOW_LOG2;
  localparam int MW      = 2*WIDTH;
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int KW      = $clog2(MW + LOG_FRAC_BITS);
  localparam int LQW     = KW + LOG_FRAC_BITS;
  localparam int LOG_REF = 8 * (2*WIDTH - 2);
  localparam logic [BCD_W-1:0] FLOOR_BCD = to_bcd3(DB_FLOOR);

  // ---------------- accumulation ----------------
  logic [CHANNELS-1:0][MW-1:0] sq;
  logic [CHANNELS-1:0][AW-1:0] acc_sum;
  logic [CHANNELS-1:0][AW-1:0] acc_q, acc_d, snap_q, snap_d;
  logic [WINDOW_LOG2-1:0]      cnt_q, cnt_d;
  logic                        overrun_q, overrun_d;
  logic                        win_end, snap_take;
  state_t                      state_q, state_d;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_sq
    logic signed [WIDTH-1:0] s_w;
    logic signed [MW-1:0]    s_x;
    assign s_w        = samples[c*WIDTH +: WIDTH];
    assign s_x        = MW'(s_w);
    assign sq[c]      = $unsigned(s_x * s_x);
    assign acc_sum[c] = acc_q[c] + AW'(sq[c]);
  end

  assign win_end   = sample_valid && (cnt_q == '1);
  assign snap_take = win_end && (state_q == ST_IDLE);

  always_comb begin
    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    overrun_d = overrun_q;
    if (sample_valid) begin
      cnt_d = cnt_q + 1'b1;
      acc_d = win_end ? '0 : acc_sum;
    end
    if (win_end) begin
      if (state_q == ST_IDLE) snap_d = acc_sum;
      else                    overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_48 or negedge reset_n) begin
    // NOTE: accumulators and snapshots are register arrays that must restart from zero, so they are reset.
    if (!reset_n) begin
      acc_q     <= '0;
      snap_q    <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      acc_q     <= acc_d;
      snap_q    <= snap_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  // ---------------- log2 / dB ----------------
  logic [CW-1:0]                ch_q, ch_d;
  logic [LQW-1:0]               log2q_q, log2q_d, lead_log2q;
  logic                         floor_q, floor_d;
  logic signed [D_W-1:0]        d_q, d_d, d_scaled;
  logic [BIN_W-1:0]             d_abs;
  logic [MW-1:0]                ms;
  logic [MW+LOG_FRAC_BITS-1:0]  ms_pad;
  logic [KW-1:0]                lead_k;
  int                           scale_val;

  always_comb begin
    ms     = snap_q[ch_q][AW-1:WINDOW_LOG2];
    ms_pad = {ms, {LOG_FRAC_BITS{1'b0}}};
    lead_k = '0;
    for (int i = 0; i < MW; i++) begin
      if (ms[i]) lead_k = KW'(i);
    end
    // {k, f} is 8*k + f; the padded vector supplies zeros when k < 3.
    lead_log2q = {lead_k, ms_pad[lead_k +: LOG_FRAC_BITS]};
  end

  always_comb begin
    scale_val = ((int'(log2q_q) - LOG_REF) * DB_SCALE_Q + DB_ROUND) >>> DB_SHIFT;
    if (floor_q || scale_val < -DB_FLOOR) scale_val = -DB_FLOOR;
    if (scale_val > 0) scale_val = 0;
    d_scaled = D_W'(scale_val);
    d_abs    = BIN_W'(-scale_val);
  end

  logic             bcd_start, bcd_done;
  logic [BCD_W-1:0] bcd_res;

  level_bcd_seq u_bcd (
    .clk_48  (clk_48),
    .reset_n (reset_n),
    .start   (bcd_start),
    .bin     (d_abs),
    .done    (bcd_done),
    .bcd     (bcd_res)
  );

  // ---------------- conversion FSM ----------------
  logic [CHANNELS-1:0][BCD_W-1:0] db_bcd_q, db_bcd_d;
  logic [CHANNELS-1:0]            db_neg_q, db_neg_d;

  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    log2q_d   = log2q_q;
    floor_d   = floor_q;
    d_d       = d_q;
    bcd_start = 1'b0;
    db_bcd_d  = db_bcd_q;
    db_neg_d  = db_neg_q;
    unique case (state_q)
      ST_IDLE: begin
        if (snap_take) begin
          state_d = ST_LOG;
          ch_d    = '0;
        end
      end
      ST_LOG: begin
        log2q_d = lead_log2q;
        floor_d = (ms == '0);
        state_d = ST_SCALE;
      end
      ST_SCALE: begin
        d_d       = d_scaled;
        bcd_start = 1'b1;
        state_d   = ST_BCD;
      end
      ST_BCD: begin
        if (bcd_done) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        db_bcd_d[ch_q] = bcd_res;
        db_neg_d[ch_q] = d_q[D_W-1];
        if (ch_q == CW'(CHANNELS-1)) begin
          state_d = ST_DONE;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = ST_LOG;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      ch_q     <= '0;
      log2q_q  <= '0;
      floor_q  <= 1'b0;
      d_q      <= '0;
      db_bcd_q <= {CHANNELS{FLOOR_BCD}};
      db_neg_q <= '1;
    end else begin
      ch_q     <= ch_d;
      log2q_q  <= log2q_d;
      floor_q  <= floor_d;
      d_q      <= d_d;
      db_bcd_q <= db_bcd_d;
      db_neg_q <= db_neg_d;
    end
  end

  assign db_bcd      = db_bcd_q;
  assign db_neg      = db_neg_q;
  assign level_valid = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);
  assign overrun     = overrun_q;

  // ---------------- peak hold ----------------
`ifdef LEVEL_METER_PEAK_HOLD_EN
  localparam int HW = $clog2(HOLD_WINDOWS + 1);
  localparam logic [D_W-1:0] FLOOR_D = D_W'(-DB_FLOOR);

  logic [CHANNELS-1:0][BCD_W-1:0] peak_bcd_q, peak_bcd_d;
  logic [CHANNELS-1:0]            peak_neg_q, peak_neg_d;
  logic [CHANNELS-1:0][D_W-1:0]   peak_val_q, peak_val_d;
  logic [CHANNELS-1:0][HW-1:0]    hold_q, hold_d;

  always_comb begin
    peak_bcd_d = peak_bcd_q;
    peak_neg_d = peak_neg_q;
    peak_val_d = peak_val_q;
    hold_d     = hold_q;
    if (state_q == ST_NEXT) begin
      if (d_q > $signed(peak_val_q[ch_q]) || hold_q[ch_q] == HW'(HOLD_WINDOWS)) begin
        peak_bcd_d[ch_q] = bcd_res;
        peak_neg_d[ch_q] = d_q[D_W-1];
        peak_val_d[ch_q] = d_q;
        hold_d[ch_q]     = '0;
      end else begin
        hold_d[ch_q] = hold_q[ch_q] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      peak_bcd_q <= {CHANNELS{FLOOR_BCD}};
      peak_neg_q <= '1;
      peak_val_q <= {CHANNELS{FLOOR_D}};
      hold_q     <= '0;
    end else begin
      peak_bcd_q <= peak_bcd_d;
      peak_neg_q <= peak_neg_d;
      peak_val_q <= peak_val_d;
      hold_q     <= hold_d;
    end
  end

  assign peak_bcd = peak_bcd_q;
  assign peak_neg = peak_neg_q;
`else
  assign peak_bcd = db_bcd;
  assign peak_neg = db_neg;
`endif

endmodule

// File: tb/tb_level_meter_mc.sv
// Directed scoreboard bench for level_meter_mc (2 channels, 16-bit, 16-sample window)
// plus a second instance with a 2-sample window for the overrun flag.
module tb_level_meter_mc;

  localparam int HOLD = 8;

  logic        clk_48 = 1'b0;
  logic        reset_n;
  logic        sample_valid;
  logic [31:0] samples;
  logic [23:0] db_bcd, peak_bcd;
  logic [1:0]  db_neg, peak_neg;
  logic        level_valid, busy, overrun;

  logic        sv_ov;
  logic [31:0] samples_ov;
  logic [23:0] db_bcd_ov, peak_bcd_ov;
  logic [1:0]  db_neg_ov, peak_neg_ov;
  logic        lv_ov, busy_ov, overrun_ov;

  always #5 clk_48 = ~clk_48;

  level_meter_mc #(.CHANNELS(2), .WIDTH(16), .WINDOW_LOG2(4), .DB_FLOOR(99), .HOLD_WINDOWS(HOLD)) dut (
    .clk_48(clk_48), .reset_n(reset_n), .sample_valid(sample_valid), .samples(samples),
    .db_bcd(db_bcd), .db_neg(db_neg), .peak_bcd(peak_bcd), .peak_neg(peak_neg),
    .level_valid(level_valid), .busy(busy), .overrun(overrun)
  );

  level_meter_mc #(.CHANNELS(2), .WIDTH(16), .WINDOW_LOG2(1), .DB_FLOOR(99), .HOLD_WINDOWS(HOLD)) dut_ov (
    .clk_48(clk_48), .reset_n(reset_n), .sample_valid(sv_ov), .samples(samples_ov),
    .db_bcd(db_bcd_ov), .db_neg(db_neg_ov), .peak_bcd(peak_bcd_ov), .peak_neg(peak_neg_ov),
    .level_valid(lv_ov), .busy(busy_ov), .overrun(overrun_ov)
  );

  typedef struct {
    int d0;
    int d1;
    int p0;
    int p1;
    int t_snap;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   pulses = 0;
  int   ref_lat = -1;
  int   m_peak[2];
  int   m_hold[2];

  always @(posedge clk_48) cyc <= cyc + 1;

  function automatic logic [11:0] bcd3(input int v);
    int a;
    a = (v < 0) ? -v : v;
    return {4'(a / 100), 4'((a / 10) % 10), 4'(a % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_peak[c] = -99;
      m_hold[c] = 0;
    end
  endtask

  function automatic int model_peak(input int c, input int d);
`ifdef LEVEL_METER_PEAK_HOLD_EN
    if (d > m_peak[c] || m_hold[c] == HOLD) begin
      m_peak[c] = d;
      m_hold[c] = 0;
    end else begin
      m_hold[c]++;
    end
    return m_peak[c];
`else
    return d;
`endif
  endfunction

  task automatic push_exp(input int d0, input int d1);
    exp_t e;
    e.d0     = d0;
    e.d1     = d1;
    e.p0     = model_peak(0, d0);
    e.p1     = model_peak(1, d1);
    e.t_snap = cyc;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: every level_valid pulse must match the oldest pending window.
  always @(negedge clk_48) begin
    if (level_valid) begin
      pulses++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_level_valid: observed pulse at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        int   lat;
        e = sb.pop_front();
        check("ch0_db_bcd", 32'(db_bcd[11:0]), 32'(bcd3(e.d0)));
        check("ch0_db_neg", 32'(db_neg[0]), 32'(e.d0 < 0));
        check("ch1_db_bcd", 32'(db_bcd[23:12]), 32'(bcd3(e.d1)));
        check("ch1_db_neg", 32'(db_neg[1]), 32'(e.d1 < 0));
        check("ch0_peak_bcd", 32'(peak_bcd[11:0]), 32'(bcd3(e.p0)));
        check("ch0_peak_neg", 32'(peak_neg[0]), 32'(e.p0 < 0));
        check("ch1_peak_bcd", 32'(peak_bcd[23:12]), 32'(bcd3(e.p1)));
        check("ch1_peak_neg", 32'(peak_neg[1]), 32'(e.p1 < 0));
        lat = cyc - e.t_snap;
        if (ref_lat < 0) ref_lat = lat;
        else check("latency", 32'(lat), 32'(ref_lat));
      end
    end
  end

  // 16 samples: (a0,a1) for the first 8, (b0,b1) for the last 8; optional idle gap after each.
  task automatic drive_window(input int a0, input int a1, input int b0, input int b1,
                              input bit gap, input bit push, input int d0, input int d1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_48);
      sample_valid = 1'b1;
      samples = (i < 8) ? {16'(a1), 16'(a0)} : {16'(b1), 16'(b0)};
      if (i == 15 && push) push_exp(d0, d1);
      if (gap) begin
        @(negedge clk_48);
        sample_valid = 1'b0;
      end
    end
    if (!gap) begin
      @(negedge clk_48);
      sample_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk_48);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk_48);
  endtask

  task automatic do_reset();
    @(negedge clk_48);
    reset_n = 1'b0;
    sample_valid = 1'b0;
    sv_ov = 1'b0;
    repeat (2) @(negedge clk_48);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk_48);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    sample_valid = 1'b0;
    samples = '0;
    sv_ov = 1'b0;
    samples_ov = '0;
    model_reset();
    repeat (3) @(negedge clk_48);
    reset_n = 1'b1;
    @(negedge clk_48);

    check("rst_db_bcd", 32'(db_bcd), 32'h099099);
    check("rst_db_neg", 32'(db_neg), 32'h3);
    check("rst_peak_bcd", 32'(peak_bcd), 32'h099099);
    check("rst_peak_neg", 32'(peak_neg), 32'h3);
    check("rst_level_valid", 32'(level_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);

    // Full scale on ch0, silence on ch1.
    pulses = 0;
    drive_window(-32768, 0, -32768, 0, 1'b0, 1'b1, 0, -99);
    check("busy_during_conv", 32'(busy), 32'h1);
    wait_drain();
    check("one_pulse_fs", 32'(pulses), 32'd1);

    drive_window(0, 16384, 0, 16384, 1'b0, 1'b1, -99, -6);
    wait_drain();
    drive_window(1, 1, 1, 1, 1'b0, 1'b1, -90, -90);
    wait_drain();
    drive_window(4096, -256, 4096, -256, 1'b0, 1'b1, -18, -42);
    wait_drain();
    // Averaging: ch1 half 16384, half zero -> mean square 2^27.
    drive_window(32767, 16384, 32767, 0, 1'b0, 1'b1, 0, -9);
    wait_drain();
    check("no_overrun_main", 32'(overrun), 32'h0);

    // Reset in the middle of a conversion.
    drive_window(-32768, -32768, -32768, -32768, 1'b0, 1'b0, 0, 0);
    repeat (4) @(negedge clk_48);
    check("busy_before_rst", 32'(busy), 32'h1);
    do_reset();
    check("midconv_busy", 32'(busy), 32'h0);
    check("midconv_db_bcd", 32'(db_bcd), 32'h099099);
    check("midconv_db_neg", 32'(db_neg), 32'h3);
    repeat (40) @(negedge clk_48);
    check("midconv_no_pulse", 32'(level_valid), 32'h0);

    // Reset in the middle of a window: the partial window must be forgotten.
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_48);
      sample_valid = 1'b1;
      samples = {16'h8000, 16'h8000};
    end
    do_reset();
    drive_window(1, 1, 1, 1, 1'b0, 1'b1, -90, -90);
    wait_drain();
    check("midwin_one_pulse", 32'(pulses), 32'd1);

    // Streaming windows (sampling continues while busy): full scale then nine quiet windows.
    do_reset();
    drive_window(-32768, -32768, -32768, -32768, 1'b1, 1'b1, 0, 0);
    for (int w = 0; w < 9; w++) begin
      drive_window(1, 1, 1, 1, 1'b1, 1'b1, -90, -90);
    end
    wait_drain();
    check("stream_no_overrun", 32'(overrun), 32'h0);

    // Two-sample window with continuous samples: conversions cannot keep up.
    do_reset();
    check("ov_rst", 32'(overrun_ov), 32'h0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_48);
      sv_ov = 1'b1;
      samples_ov = {16'(i * 37), 16'(-i * 91)};
    end
    @(negedge clk_48);
    sv_ov = 1'b0;
    check("ov_set", 32'(overrun_ov), 32'h1);
    repeat (60) @(negedge clk_48);
    check("ov_sticky", 32'(overrun_ov), 32'h1);
    check("ov_main_clear", 32'(overrun), 32'h0);
    do_reset();
    check("ov_cleared", 32'(overrun_ov), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
